// File: rtl/ahb_apb_ctrl_if.sv
// AHB-Lite slave-side and APB master-side signal bundle for the AHB-to-APB bridge controller.
// The slave modport is the controller's view; the master modport is the bridge top / bench view.
interface ahb_apb_ctrl_if #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int NUM_SLAVES = 3
);
    logic [1:0]            Htrans;
    logic                  Hwrite;
    logic [ADDR_W-1:0]     Haddr;
    logic [DATA_W-1:0]     Hwdata;
    logic [2:0]            Hsize;
    logic                  Hreadyin;
    logic                  Hreadyout;
    logic [1:0]            Hresp;
    logic [DATA_W-1:0]     Hrdata;
    logic [NUM_SLAVES-1:0] Psel;
    logic                  Penable;
    logic                  Pwrite;
    logic [ADDR_W-1:0]     Paddr;
    logic [DATA_W-1:0]     Pwdata;
    logic [DATA_W-1:0]     Prdata;
    logic                  Pready;
    logic                  Pslverr;

    modport slave (
        input  Htrans, Hwrite, Haddr, Hwdata, Hsize, Hreadyin, Prdata, Pready, Pslverr,
        output Hreadyout, Hresp, Hrdata, Psel, Penable, Pwrite, Paddr, Pwdata
    );

    modport master (
        output Htrans, Hwrite, Haddr, Hwdata, Hsize, Hreadyin, Prdata, Pready, Pslverr,
        input  Hreadyout, Hresp, Hrdata, Psel, Penable, Pwrite, Paddr, Pwdata
    );
endinterface

// File: rtl/ahb_apb_ctrl.sv
// AHB-Lite to APB bridge controller FSM: decodes the slave, runs SETUP/ENABLE, stalls AHB and returns data/response.
// Optional macro AHB_APB_PSLVERR_EN turns an APB Pslverr into a two-cycle AHB ERROR response.
module ahb_apb_ctrl #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int NUM_SLAVES = 3
) (
    input  logic Hclk,
    input  logic Hreset,
    ahb_apb_ctrl_if.slave bus
);
    localparam logic [1:0] RESP_OKAY = 2'b00;
    localparam logic [1:0] RESP_ERR  = 2'b01;

    typedef enum logic [2:0] {IDLE, WWAIT, SETUP, ENABLE, ERR1, ERR2} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic                pwrite_q, pwrite_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;
    logic [3:0]          idx_q, idx_d;

    logic                valid_xfer;
    logic                legal_xfer;
    logic                slverr;
    logic                accept;
    logic                sel_en;
    logic                hreadyout;
    logic [1:0]          hresp;
    logic                penable;
    logic [DATA_W-1:0]   hrdata;
    logic [NUM_SLAVES-1:0] psel;

    assign valid_xfer = bus.Hreadyin & bus.Htrans[1];
    assign legal_xfer = (bus.Haddr[31:28] == 4'h8)
                     && ({1'b0, bus.Haddr[27:24]} < 5'(NUM_SLAVES))
                     && (bus.Hsize <= 3'b010);

`ifdef AHB_APB_PSLVERR_EN
    assign slverr = bus.Pslverr;
`else
    // Pslverr is deliberately ignored in this build; the port stays for a uniform bridge top.
    logic unused_pslverr;
    assign unused_pslverr = bus.Pslverr;
    assign slverr = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        paddr_d   = paddr_q;
        pwrite_d  = pwrite_q;
        pwdata_d  = pwdata_q;
        idx_d     = idx_q;
        hreadyout = 1'b1;
        hresp     = RESP_OKAY;
        penable   = 1'b0;
        sel_en    = 1'b0;
        hrdata    = '0;
        accept    = 1'b0;

        case (state_q)
            IDLE: accept = 1'b1;
            WWAIT: begin
                hreadyout = 1'b0;
                pwdata_d  = bus.Hwdata;
                state_d   = SETUP;
            end
            SETUP: begin
                hreadyout = 1'b0;
                sel_en    = 1'b1;
                state_d   = ENABLE;
            end
            ENABLE: begin
                sel_en  = 1'b1;
                penable = 1'b1;
                if (!bus.Pready) begin
                    hreadyout = 1'b0;
                end else if (slverr) begin
                    hreadyout = 1'b0;
                    hresp     = RESP_ERR;
                    state_d   = ERR2;
                end else begin
                    hrdata = bus.Prdata;
                    accept = 1'b1;
                end
            end
            ERR1: begin
                hreadyout = 1'b0;
                hresp     = RESP_ERR;
                state_d   = ERR2;
            end
            ERR2: begin
                hresp  = RESP_ERR;
                accept = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        // Completion points double as address-phase decode so back-to-back transfers skip IDLE.
        if (accept) begin
            if (valid_xfer) begin
                if (legal_xfer) begin
                    paddr_d  = bus.Haddr;
                    pwrite_d = bus.Hwrite;
                    idx_d    = bus.Haddr[27:24];
                    state_d  = bus.Hwrite ? WWAIT : SETUP;
                end else begin
                    state_d = ERR1;
                end
            end else begin
                state_d = IDLE;
            end
        end
    end

    always_comb begin
        psel = '0;
        if (sel_en) begin
            for (int i = 0; i < NUM_SLAVES; i++) begin
                psel[i] = (idx_q == 4'(i));
            end
        end
    end

    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            state_q  <= IDLE;
            paddr_q  <= '0;
            pwrite_q <= 1'b0;
            pwdata_q <= '0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            paddr_q  <= paddr_d;
            pwrite_q <= pwrite_d;
            pwdata_q <= pwdata_d;
            idx_q    <= idx_d;
        end
    end

    assign bus.Hreadyout = hreadyout;
    assign bus.Hresp     = hresp;
    assign bus.Hrdata    = hrdata;
    assign bus.Psel      = psel;
    assign bus.Penable   = penable;
    assign bus.Pwrite    = pwrite_q;
    assign bus.Paddr     = paddr_q;
    assign bus.Pwdata    = pwdata_q;
endmodule

// File: tb/tb_ahb_apb_ctrl.sv
// Directed bench for ahb_apb_ctrl: reset, read, write with wait states, decode errors,
// back-to-back transfers, reset mid-transfer and Pslverr handling.
module tb_ahb_apb_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    ahb_apb_ctrl_if #(.ADDR_W(32), .DATA_W(32), .NUM_SLAVES(3)) bus ();

    ahb_apb_ctrl #(.ADDR_W(32), .DATA_W(32), .NUM_SLAVES(3)) dut (
        .Hclk   (clk),
        .Hreset (rst),
        .bus    (bus.slave)
    );

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        bus.Htrans   = 2'b00;
        bus.Hwrite   = 1'b0;
        bus.Haddr    = 32'h0;
        bus.Hwdata   = 32'h0;
        bus.Hsize    = 3'b010;
        bus.Hreadyin = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus_idle();
        bus.Prdata = 32'h0; bus.Pready = 1'b1; bus.Pslverr = 1'b0;
        nxt(); nxt(); #1;
        n_cmp++; if (bus.Hreadyout !== 1'b1) begin n_bad++; $display("FAIL rst_hreadyout: got %b want 1", bus.Hreadyout); end
        n_cmp++; if (bus.Hresp !== 2'b00) begin n_bad++; $display("FAIL rst_hresp: got %b want 00", bus.Hresp); end
        n_cmp++; if (bus.Psel !== 3'b000 || bus.Penable !== 1'b0) begin n_bad++; $display("FAIL rst_psel_penable: got %b/%b want 000/0", bus.Psel, bus.Penable); end
        n_cmp++; if (bus.Paddr !== 32'h0 || bus.Pwdata !== 32'h0 || bus.Pwrite !== 1'b0) begin n_bad++; $display("FAIL rst_paddr_pwdata_pwrite: got %h/%h/%b want 0/0/0", bus.Paddr, bus.Pwdata, bus.Pwrite); end
        n_cmp++; if (bus.Hrdata !== 32'h0) begin n_bad++; $display("FAIL rst_hrdata: got %h want 0", bus.Hrdata); end
        rst = 1'b0;
    endtask

    task automatic test_read();
        nxt();
        bus.Htrans = 2'b10; bus.Hwrite = 1'b0; bus.Haddr = 32'h8100_0010; bus.Hsize = 3'b010;
        bus.Prdata = 32'hDEAD_BEEF; bus.Pready = 1'b1;
        #1;
        n_cmp++; if (bus.Hreadyout !== 1'b1) begin n_bad++; $display("FAIL rd_idle_ready: got %b want 1", bus.Hreadyout); end
        nxt(); bus_idle(); #1;
        n_cmp++; if (bus.Psel !== 3'b010 || bus.Penable !== 1'b0 || bus.Hreadyout !== 1'b0) begin n_bad++; $display("FAIL rd_setup: psel/pen/rdy got %b/%b/%b want 010/0/0", bus.Psel, bus.Penable, bus.Hreadyout); end
        n_cmp++; if (bus.Paddr !== 32'h8100_0010 || bus.Pwrite !== 1'b0) begin n_bad++; $display("FAIL rd_paddr: got %h/%b want 81000010/0", bus.Paddr, bus.Pwrite); end
        n_cmp++; if (bus.Hrdata !== 32'h0) begin n_bad++; $display("FAIL rd_setup_hrdata: got %h want 0", bus.Hrdata); end
        nxt(); #1;
        n_cmp++; if (bus.Psel !== 3'b010 || bus.Penable !== 1'b1 || bus.Hreadyout !== 1'b1) begin n_bad++; $display("FAIL rd_enable: psel/pen/rdy got %b/%b/%b want 010/1/1", bus.Psel, bus.Penable, bus.Hreadyout); end
        n_cmp++; if (bus.Hrdata !== 32'hDEAD_BEEF || bus.Hresp !== 2'b00) begin n_bad++; $display("FAIL rd_data: got %h/%b want deadbeef/00", bus.Hrdata, bus.Hresp); end
        nxt(); #1;
        n_cmp++; if (bus.Psel !== 3'b000 || bus.Penable !== 1'b0 || bus.Hrdata !== 32'h0) begin n_bad++; $display("FAIL rd_after: psel/pen/hrdata got %b/%b/%h want 000/0/0", bus.Psel, bus.Penable, bus.Hrdata); end
    endtask

    task automatic test_write_wait();
        int low_cnt = 0;
        int en_cnt  = 0;
        nxt();
        bus.Htrans = 2'b10; bus.Hwrite = 1'b1; bus.Haddr = 32'h8200_0004; bus.Hsize = 3'b010;
        bus.Pready = 1'b0;
        nxt();
        bus_idle(); bus.Hwdata = 32'h1234_5678; #1;
        if (bus.Hreadyout == 1'b0) low_cnt++;
        n_cmp++; if (bus.Psel !== 3'b000 || bus.Hreadyout !== 1'b0) begin n_bad++; $display("FAIL wr_wwait: psel/rdy got %b/%b want 000/0", bus.Psel, bus.Hreadyout); end
        nxt(); #1;
        if (bus.Hreadyout == 1'b0) low_cnt++;
        n_cmp++; if (bus.Pwdata !== 32'h1234_5678 || bus.Pwrite !== 1'b1 || bus.Paddr !== 32'h8200_0004) begin n_bad++; $display("FAIL wr_setup_regs: pwdata/pwrite/paddr got %h/%b/%h want 12345678/1/82000004", bus.Pwdata, bus.Pwrite, bus.Paddr); end
        n_cmp++; if (bus.Psel !== 3'b100 || bus.Penable !== 1'b0) begin n_bad++; $display("FAIL wr_setup_sel: psel/pen got %b/%b want 100/0", bus.Psel, bus.Penable); end
        for (int c = 0; c < 3; c++) begin
            nxt();
            if (c == 2) bus.Pready = 1'b1;
            #1;
            if (bus.Hreadyout == 1'b0) low_cnt++;
            if (bus.Penable == 1'b1 && bus.Psel == 3'b100) en_cnt++;
        end
        n_cmp++; if (bus.Hreadyout !== 1'b1 || bus.Hresp !== 2'b00) begin n_bad++; $display("FAIL wr_done: rdy/resp got %b/%b want 1/00", bus.Hreadyout, bus.Hresp); end
        n_cmp++; if (low_cnt !== 4) begin n_bad++; $display("FAIL wr_low_cycles: got %0d want 4", low_cnt); end
        n_cmp++; if (en_cnt !== 3) begin n_bad++; $display("FAIL wr_enable_cycles: got %0d want 3", en_cnt); end
        nxt(); #1;
        n_cmp++; if (bus.Psel !== 3'b000 || bus.Penable !== 1'b0) begin n_bad++; $display("FAIL wr_after: psel/pen got %b/%b want 000/0", bus.Psel, bus.Penable); end
    endtask

    task automatic test_decode_err();
        logic [31:0] addr_v [2];
        logic [2:0]  size_v [2];
        addr_v[0] = 32'h8300_0000; size_v[0] = 3'b010;
        addr_v[1] = 32'h8000_0000; size_v[1] = 3'b011;
        for (int k = 0; k < 2; k++) begin
            nxt();
            bus.Htrans = 2'b10; bus.Hwrite = 1'b0; bus.Haddr = addr_v[k]; bus.Hsize = size_v[k];
            nxt(); bus_idle(); #1;
            n_cmp++; if (bus.Psel !== 3'b000 || bus.Hreadyout !== 1'b0 || bus.Hresp !== 2'b01) begin n_bad++; $display("FAIL err1_%0d: psel/rdy/resp got %b/%b/%b want 000/0/01", k, bus.Psel, bus.Hreadyout, bus.Hresp); end
            nxt(); #1;
            n_cmp++; if (bus.Psel !== 3'b000 || bus.Hreadyout !== 1'b1 || bus.Hresp !== 2'b01) begin n_bad++; $display("FAIL err2_%0d: psel/rdy/resp got %b/%b/%b want 000/1/01", k, bus.Psel, bus.Hreadyout, bus.Hresp); end
            nxt(); #1;
            n_cmp++; if (bus.Hresp !== 2'b00 || bus.Psel !== 3'b000) begin n_bad++; $display("FAIL err_after_%0d: resp/psel got %b/%b want 00/000", k, bus.Hresp, bus.Psel); end
        end
    endtask

    task automatic test_back_to_back();
        nxt();
        bus.Htrans = 2'b10; bus.Hwrite = 1'b0; bus.Haddr = 32'h8000_0000; bus.Hsize = 3'b010;
        bus.Pready = 1'b1; bus.Prdata = 32'h0BAD_F00D;
        nxt(); bus_idle(); #1;
        n_cmp++; if (bus.Psel !== 3'b001) begin n_bad++; $display("FAIL b2b_rd_setup: psel got %b want 001", bus.Psel); end
        nxt();
        bus.Htrans = 2'b10; bus.Hwrite = 1'b1; bus.Haddr = 32'h8100_0000; #1;
        n_cmp++; if (bus.Penable !== 1'b1 || bus.Hreadyout !== 1'b1 || bus.Hrdata !== 32'h0BAD_F00D) begin n_bad++; $display("FAIL b2b_rd_enable: pen/rdy/hrdata got %b/%b/%h want 1/1/0badf00d", bus.Penable, bus.Hreadyout, bus.Hrdata); end
        nxt(); bus_idle(); bus.Hwdata = 32'hA5A5_5A5A; #1;
        n_cmp++; if (bus.Penable !== 1'b0 || bus.Psel !== 3'b000 || bus.Hreadyout !== 1'b0) begin n_bad++; $display("FAIL b2b_wwait: pen/psel/rdy got %b/%b/%b want 0/000/0", bus.Penable, bus.Psel, bus.Hreadyout); end
        nxt(); #1;
        n_cmp++; if (bus.Psel !== 3'b010 || bus.Penable !== 1'b0 || bus.Paddr !== 32'h8100_0000 || bus.Pwdata !== 32'hA5A5_5A5A) begin n_bad++; $display("FAIL b2b_wr_setup: psel/pen/paddr/pwdata got %b/%b/%h/%h want 010/0/81000000/a5a55a5a", bus.Psel, bus.Penable, bus.Paddr, bus.Pwdata); end
        nxt();
        bus.Htrans = 2'b10; bus.Hwrite = 1'b0; bus.Haddr = 32'h8000_0008; #1;
        n_cmp++; if (bus.Penable !== 1'b1 || bus.Hreadyout !== 1'b1 || bus.Pwrite !== 1'b1) begin n_bad++; $display("FAIL b2b_wr_enable: pen/rdy/pwrite got %b/%b/%b want 1/1/1", bus.Penable, bus.Hreadyout, bus.Pwrite); end
        nxt(); bus_idle(); #1;
        n_cmp++; if (bus.Psel !== 3'b001 || bus.Penable !== 1'b0 || bus.Pwrite !== 1'b0 || bus.Paddr !== 32'h8000_0008) begin n_bad++; $display("FAIL b2b_rd2_setup: psel/pen/pwrite/paddr got %b/%b/%b/%h want 001/0/0/80000008", bus.Psel, bus.Penable, bus.Pwrite, bus.Paddr); end
        nxt(); nxt(); #1;
    endtask

    task automatic test_reset_mid();
        nxt();
        bus.Htrans = 2'b10; bus.Hwrite = 1'b0; bus.Haddr = 32'h8100_0000; bus.Pready = 1'b0;
        nxt(); bus_idle();
        nxt(); #1;
        n_cmp++; if (bus.Penable !== 1'b1 || bus.Hreadyout !== 1'b0) begin n_bad++; $display("FAIL rm_enable_stall: pen/rdy got %b/%b want 1/0", bus.Penable, bus.Hreadyout); end
        rst = 1'b1;
        nxt();
        rst = 1'b0; bus.Pready = 1'b1; #1;
        n_cmp++; if (bus.Psel !== 3'b000 || bus.Penable !== 1'b0 || bus.Hreadyout !== 1'b1 || bus.Hresp !== 2'b00) begin n_bad++; $display("FAIL rm_after_reset: psel/pen/rdy/resp got %b/%b/%b/%b want 000/0/1/00", bus.Psel, bus.Penable, bus.Hreadyout, bus.Hresp); end
        bus.Htrans = 2'b01; bus.Haddr = 32'h8100_0000;
        nxt(); bus.Htrans = 2'b00; #1;
        n_cmp++; if (bus.Psel !== 3'b000 || bus.Hreadyout !== 1'b1 || bus.Paddr !== 32'h0) begin n_bad++; $display("FAIL rm_busy_ignored: psel/rdy/paddr got %b/%b/%h want 000/1/0", bus.Psel, bus.Hreadyout, bus.Paddr); end
        nxt(); #1;
        n_cmp++; if (bus.Psel !== 3'b000 || bus.Hreadyout !== 1'b1) begin n_bad++; $display("FAIL rm_idle_ignored: psel/rdy got %b/%b want 000/1", bus.Psel, bus.Hreadyout); end
        bus_idle();
    endtask

    task automatic test_pslverr();
        nxt();
        bus.Htrans = 2'b10; bus.Hwrite = 1'b0; bus.Haddr = 32'h8000_0000;
        bus.Pready = 1'b1; bus.Pslverr = 1'b1; bus.Prdata = 32'h1111_2222;
        nxt(); bus_idle();
        nxt(); #1;
`ifdef AHB_APB_PSLVERR_EN
        n_cmp++; if (bus.Hreadyout !== 1'b0 || bus.Hresp !== 2'b01 || bus.Hrdata !== 32'h0) begin n_bad++; $display("FAIL slverr_c1: rdy/resp/hrdata got %b/%b/%h want 0/01/0", bus.Hreadyout, bus.Hresp, bus.Hrdata); end
        nxt(); #1;
        n_cmp++; if (bus.Hreadyout !== 1'b1 || bus.Hresp !== 2'b01 || bus.Psel !== 3'b000) begin n_bad++; $display("FAIL slverr_c2: rdy/resp/psel got %b/%b/%b want 1/01/000", bus.Hreadyout, bus.Hresp, bus.Psel); end
`else
        n_cmp++; if (bus.Hreadyout !== 1'b1 || bus.Hresp !== 2'b00 || bus.Hrdata !== 32'h1111_2222) begin n_bad++; $display("FAIL slverr_ignored_c1: rdy/resp/hrdata got %b/%b/%h want 1/00/11112222", bus.Hreadyout, bus.Hresp, bus.Hrdata); end
        nxt(); #1;
        n_cmp++; if (bus.Hreadyout !== 1'b1 || bus.Hresp !== 2'b00 || bus.Psel !== 3'b000) begin n_bad++; $display("FAIL slverr_ignored_c2: rdy/resp/psel got %b/%b/%b want 1/00/000", bus.Hreadyout, bus.Hresp, bus.Psel); end
`endif
        bus.Pslverr = 1'b0;
        nxt(); #1;
        n_cmp++; if (bus.Hresp !== 2'b00 || bus.Hreadyout !== 1'b1) begin n_bad++; $display("FAIL slverr_after: resp/rdy got %b/%b want 00/1", bus.Hresp, bus.Hreadyout); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_read();
        test_write_wait();
        test_decode_err();
        test_back_to_back();
        test_reset_mid();
        test_pslverr();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ahb_apb_ctrl.md
Name: ahb_apb_ctrl

Overview:
Bridge controller FSM that sequences AHB-Lite slave-side transfers into APB setup/access phases.
- Decodes the target APB slave from the address.
- Stalls AHB via Hreadyout while the APB transfer runs.
- Returns read data and OKAY/ERROR responses.
- Sits between the AHB slave interface signals and up to NUM_SLAVES APB peripherals inside the bridge top.

Parameters:
ADDR_W, 32, address width (AHB and APB)
DATA_W, 32, data width (Hwdata/Hrdata/Pwdata/Prdata)
NUM_SLAVES, 3, number of APB slaves; Psel one-hot width (max 16)

Ports:
Hclk  in  1  clock
Hreset  in  1  synchronous reset, active-high
Htrans  in  2  AHB transfer type (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ)
Hwrite  in  1  1=write
Haddr  in  ADDR_W  AHB address
Hwdata  in  DATA_W  AHB write data (valid in data phase)
Hsize  in  3  transfer size
Hreadyin  in  1  AHB bus ready
Hreadyout  out  1  slave ready to AHB
Hresp  out  2  00 OKAY, 01 ERROR
Hrdata  out  DATA_W  read data to AHB
Psel  out  NUM_SLAVES  one-hot APB select
Penable  out  1  APB access phase
Pwrite  out  1  APB direction
Paddr  out  ADDR_W  APB address
Pwdata  out  DATA_W  APB write data
Prdata  in  DATA_W  APB read data (muxed by bridge top)
Pready  in  1  APB ready
Pslverr  in  1  APB slave error

Behaviour:
- Reset (Hreset=1 at posedge): next state IDLE.
  - Hreadyout=1, Hresp=00, Psel=0, Penable=0, Pwrite=0, Paddr=0, Pwdata=0, Hrdata=0.
  - Reset mid-transfer aborts the APB cycle at that edge; no completion is reported.
- Valid transfer: Hreadyin=1 and Htrans[1]=1, sampled at posedge in IDLE, ENABLE (when completing) or ERR2.
  - BUSY and IDLE transfers are ignored.
- Decode: legal iff Haddr[31:28]==4'h8, Haddr[27:24]<NUM_SLAVES and Hsize<=3'b010.
  - Slave index = Haddr[27:24].
  - Any illegal transfer goes to ERR1.
- On accepting a legal transfer, latch Paddr<=Haddr, Pwrite<=Hwrite and the slave index.
- States and outputs:
  - IDLE: Hreadyout=1, Psel=0.
    - Legal write -> WWAIT; legal read -> SETUP; illegal -> ERR1.
  - WWAIT: Hreadyout=0. Captures Pwdata<=Hwdata at the edge. -> SETUP.
  - SETUP: Psel[idx]=1, Penable=0, Hreadyout=0. -> ENABLE.
  - ENABLE: Psel[idx]=1, Penable=1.
    - Pready=0: hold ENABLE with Hreadyout=0.
    - Pready=1, OKAY: Hreadyout=1, Hresp=00, Hrdata=Prdata (reads).
      - Next is the new-transfer decode as in IDLE, else IDLE.
  - ERR1: Hreadyout=0, Hresp=01, Psel=0. -> ERR2.
  - ERR2: Hreadyout=1, Hresp=01. New-transfer decode as in IDLE, else IDLE.
- Hrdata equals Prdata only in ENABLE with Pready=1; otherwise 0.
- Latency, no wait states:
  - Read: 2 cycles (address phase edge -> SETUP -> ENABLE completes).
  - Write: 3 cycles.
- Back-to-back transfers: no IDLE cycle is inserted between consecutive APB transfers.
- Psel and Penable deassert at the edge after completion unless a new transfer is accepted.
  - If one is accepted, Penable deasserts and Psel moves to the new index (or WWAIT/ERR1 drops Psel).

Optional Feature:
Macro: AHB_APB_PSLVERR_EN
- Defined: in ENABLE with Pready=1 and Pslverr=1:
  - Hreadyout=0, Hresp=01, Hrdata=0; next state ERR2.
  - The standard two-cycle AHB ERROR response completes in ERR2.
- Undefined: Pslverr is ignored and the transfer completes OKAY. The port remains present.

Test Plan:
- Read: NONSEQ read Haddr=0x8100_0010, Prdata=0xDEAD_BEEF, Pready=1.
  -> SETUP then ENABLE with Psel=3'b010, Paddr=0x8100_0010; Hrdata=0xDEAD_BEEF and Hreadyout=1 on cycle 2.
- Write with wait states: NONSEQ write Haddr=0x8200_0004, Hwdata=0x1234_5678, Pready held low 2 cycles.
  -> Pwdata=0x1234_5678, Psel=3'b100; ENABLE lasts 3 cycles; Hreadyout low for 4 cycles total.
- Decode errors: Haddr=0x8300_0000 with NUM_SLAVES=3, and separately Hsize=3'b011.
  -> Psel stays 0; ERR1 (Hreadyout=0, Hresp=01) then ERR2 (Hreadyout=1, Hresp=01).
- Back-to-back: read to 0x8000_0000, then NONSEQ write to 0x8100_0000 presented in the ENABLE cycle.
  -> Penable drops, WWAIT, SETUP with Psel=3'b010; no IDLE cycle in between.
- Reset mid-transfer: assert Hreset during ENABLE with Pready=0.
  -> Next edge: Psel=0, Penable=0, Hreadyout=1, Hresp=00; BUSY/IDLE Htrans afterwards produce no Psel.
- AHB_APB_PSLVERR_EN: read with Pslverr=1, Pready=1.
  -> Defined: Hresp=01 for 2 cycles, Hreadyout 0 then 1. Undefined: Hresp=00, Hreadyout=1.
